// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the column frame writer.
// Holds the FSM states and the header word layout.
package frame_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STROBE = 2'd2
    } state_t;

    localparam logic [7:0] FrameMagic = 8'hFA;

    localparam int MagicMsb = 31;
    localparam int MagicLsb = 24;
    localparam int IdxMsb   = 4;
    localparam int IdxLsb   = 0;
    localparam int IdxWidth = IdxMsb - IdxLsb + 1;

    // A header is accepted when the magic matches and the index is in range.
    function automatic logic hdrValid(
        input logic [31:0] word,
        input int          maxFrames
    );
        logic magicOk;
        logic idxOk;
        magicOk = (word[MagicMsb:MagicLsb] == FrameMagic);
        idxOk   = (int'(word[IdxMsb:IdxLsb]) < maxFrames);
        return magicOk && idxOk;
    endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Frame index to one-hot strobe decoder.
// The whole output is gated low when enable is deasserted.
module frame_strobe_decoder #(
    parameter int NumFrames = 20,
    parameter int IdxWidth  = 5
) (
    input  logic [IdxWidth-1:0]  frameIdx,
    input  logic                 enable,
    output logic [NumFrames-1:0] oneHot
);

    // Set only the bit matching the index, and only while enabled.
    always_comb begin
        oneHot = '0;
        for (int i = 0; i < NumFrames; i++) begin
            if (enable && (int'(frameIdx) == i)) begin
                oneHot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/col_frame_writer.sv
// Column frame writer: header, NumRows data words, then a timed strobe.
// FrameData holds its contents until the next frame overwrites it.
module col_frame_writer
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int StrobeCycles    = 2
) (
    input  logic                                 UserCLK,
    input  logic                                 resetn,
    input  logic [FrameBitsPerRow-1:0]           s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 err
);

    localparam int RowCntW = $clog2(NumRows + 1);
    localparam logic [RowCntW-1:0] LastRow = RowCntW'(NumRows - 1);
    localparam logic [3:0] LastStrobe = 4'(StrobeCycles - 1);

    state_t               state;
    state_t               stateNext;
    logic [IdxWidth-1:0]  frameIdx;
    logic [RowCntW-1:0]   rowCnt;
    logic [3:0]           strbCnt;
    logic                 accept;
    logic                 hdrOk;

    assign s_ready = resetn && (state != STROBE);
    assign busy    = (state != IDLE);
    assign accept  = s_valid && s_ready;
    assign hdrOk   = hdrValid(s_data[31:0], MaxFramesPerCol);

    // State register.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: header opens a frame, last row starts the strobe.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (accept && hdrOk) begin
                    stateNext = LOAD;
                end
            end
            LOAD: begin
                if (accept && (rowCnt == LastRow)) begin
                    stateNext = STROBE;
                end
            end
            STROBE: begin
                if (strbCnt == LastStrobe) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: latch index, store rows, count strobe cycles, flag bad headers.
    always_ff @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            frameIdx  <= '0;
            rowCnt    <= '0;
            strbCnt   <= '0;
            FrameData <= '0;
            err       <= 1'b0;
        end else begin
            err <= accept && (state == IDLE) && !hdrOk;
            unique case (state)
                IDLE: begin
                    if (accept && hdrOk) begin
                        frameIdx <= s_data[IdxMsb:IdxLsb];
                        rowCnt   <= '0;
                    end
                end
                LOAD: begin
                    strbCnt <= '0;
                    if (accept) begin
                        FrameData[int'(rowCnt)*FrameBitsPerRow +: FrameBitsPerRow]
                            <= s_data;
                        rowCnt <= rowCnt + RowCntW'(1);
                    end
                end
                STROBE: begin
                    strbCnt <= strbCnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    frame_strobe_decoder #(
        .NumFrames(MaxFramesPerCol),
        .IdxWidth (IdxWidth)
    ) uDecoder (
        .frameIdx(frameIdx),
        .enable  (state == STROBE),
        .oneHot  (FrameStrobe)
    );

endmodule

// File: tb/tb_col_frame_writer.sv
// Testbench for col_frame_writer: directed cases plus random frames.
// A transaction-level model predicts every output on each falling edge.
module tb_col_frame_writer;

    localparam int NR = 4;
    localparam int FB = 32;
    localparam int MF = 20;
    localparam int SC = 2;

    logic         UserCLK = 1'b0;
    logic         resetn  = 1'b1;
    logic [31:0]  s_data  = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [127:0] FrameData;
    logic [19:0]  FrameStrobe;
    logic         busy;
    logic         err;

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;
    int lastAcc = 0;

    col_frame_writer #(
        .MaxFramesPerCol(MF),
        .FrameBitsPerRow(FB),
        .NumRows        (NR),
        .StrobeCycles   (SC)
    ) dut (
        .UserCLK    (UserCLK),
        .resetn     (resetn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .FrameData  (FrameData),
        .FrameStrobe(FrameStrobe),
        .busy       (busy),
        .err        (err)
    );

    always #5 UserCLK = ~UserCLK;

    always @(posedge UserCLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Model: rows still to load, strobe cycles still to show, stored data.
    int           mRowsLeft   = 0;
    int           mStrobeLeft = 0;
    int           mIdx        = 0;
    logic [127:0] mData       = '0;
    logic         mErr        = 1'b0;
    logic         mAcc;
    logic [19:0]  expStrobe;

    always @(posedge UserCLK or negedge resetn) begin
        if (!resetn) begin
            mRowsLeft   = 0;
            mStrobeLeft = 0;
            mIdx        = 0;
            mData       = '0;
            mErr        = 1'b0;
        end else begin
            mAcc = s_valid && (mStrobeLeft == 0);
            mErr = 1'b0;
            if (mStrobeLeft > 0) begin
                mStrobeLeft = mStrobeLeft - 1;
            end else if (mRowsLeft > 0) begin
                if (mAcc) begin
                    mData[(NR - mRowsLeft)*FB +: FB] = s_data;
                    mRowsLeft = mRowsLeft - 1;
                    if (mRowsLeft == 0) mStrobeLeft = SC;
                end
            end else if (mAcc) begin
                if (s_data[31:24] == 8'hFA && int'(s_data[4:0]) < MF) begin
                    mIdx      = int'(s_data[4:0]);
                    mRowsLeft = NR;
                end else begin
                    mErr = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model each falling edge.
    always @(negedge UserCLK) begin
        expStrobe = '0;
        if (mStrobeLeft > 0) expStrobe[mIdx] = 1'b1;
        check("s_ready", 128'(s_ready),
              128'(resetn && (mStrobeLeft == 0)));
        check("busy", 128'(busy),
              128'((mRowsLeft > 0) || (mStrobeLeft > 0)));
        check("err", 128'(err), 128'(mErr));
        check("FrameStrobe", 128'(FrameStrobe), 128'(expStrobe));
        check("FrameData", FrameData, mData);
    end

    // Strobe burst monitor for the directed timing checks.
    int           bursts    = 0;
    int           strbStart = 0;
    int           strbLen   = 0;
    logic         inBurst   = 1'b0;
    logic [19:0]  lastStrb  = '0;
    logic [127:0] lastData  = '0;

    always @(negedge UserCLK) begin
        if (FrameStrobe != '0) begin
            if (!inBurst) begin
                strbStart = cyc;
                strbLen   = 0;
                bursts++;
            end
            strbLen++;
            lastStrb = FrameStrobe;
            lastData = FrameData;
            inBurst  = 1'b1;
        end else begin
            inBurst = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge UserCLK);
            #2;
        end
    endtask

    task automatic push(input logic [31:0] d);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && t < 50) begin
            tick(1);
            t++;
        end
        if (!s_ready) begin
            nChecks++;
            $display("FAIL push_timeout: s_ready 0 after %0d cycles, required 1", t);
        end
        lastAcc = cyc;
        tick(1);
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        s_valid = 1'b0;
        while (busy && t < 50) begin
            tick(1);
            t++;
        end
        if (busy) begin
            nChecks++;
            $display("FAIL idle_timeout: busy 1 after %0d cycles, required 0", t);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int b0;
    int c0;
    int kind;
    logic [31:0] h;

    initial begin
        #1 resetn = 1'b0;
        #1;
        check("rst_ready", 128'(s_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_strobe", 128'(FrameStrobe), 128'(0));
        check("rst_data", FrameData, 128'(0));
        check("rst_err", 128'(err), 128'(0));
        tick(3);
        resetn = 1'b1;
        tick(2);

        // Basic frame, valid held high.
        push(32'hFA000003);
        c0 = lastAcc;
        push(32'h11111111);
        push(32'h22222222);
        push(32'h33333333);
        push(32'h44444444);
        waitIdle();
        tick(1);
        check("t1_latency", 128'(strbStart - c0), 128'(5));
        check("t1_len", 128'(strbLen), 128'(2));
        check("t1_strobe", 128'(lastStrb), 128'(20'h00008));
        check("t1_data", lastData,
              128'h44444444_33333333_22222222_11111111);

        // Bad magic.
        b0 = bursts;
        push(32'hAB000001);
        s_valid = 1'b0;
        check("t2_err", 128'(err), 128'(1));
        check("t2_busy", 128'(busy), 128'(0));
        tick(1);
        check("t2_err_gone", 128'(err), 128'(0));
        tick(3);
        check("t2_nostrobe", 128'(bursts), 128'(b0));

        // Index out of range, then highest legal index.
        push(32'hFA000014);
        s_valid = 1'b0;
        check("t3_err", 128'(err), 128'(1));
        tick(3);
        check("t3_nostrobe", 128'(bursts), 128'(b0));
        push(32'hFA000013);
        for (int w = 0; w < NR; w++) push($urandom);
        waitIdle();
        tick(1);
        check("t3_strobe19", 128'(lastStrb), 128'(20'h80000));

        // Gaps in valid during the load.
        b0 = bursts;
        push(32'hFA000002);
        for (int w = 0; w < NR; w++) begin
            s_valid = 1'b0;
            s_data  = 32'hDEADBEEF;
            tick(1);
            push({4{8'(8'hA1 + 8'(w))}});
        end
        waitIdle();
        tick(1);
        check("t4_bursts", 128'(bursts), 128'(b0 + 1));
        check("t4_data", lastData,
              128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1);

        // Reset during load.
        push(32'hFA000001);
        push(32'h12345678);
        push(32'h9ABCDEF0);
        s_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("t5a_data", FrameData, 128'(0));
        check("t5a_busy", 128'(busy), 128'(0));
        check("t5a_ready", 128'(s_ready), 128'(0));
        tick(1);
        resetn = 1'b1;
        tick(1);

        // Reset during strobe.
        push(32'hFA000009);
        for (int w = 0; w < NR; w++) push($urandom);
        s_valid = 1'b0;
        check("t5b_instrobe", 128'(FrameStrobe), 128'(20'h00200));
        resetn = 1'b0;
        #1;
        check("t5b_strobe", 128'(FrameStrobe), 128'(0));
        check("t5b_data", FrameData, 128'(0));
        check("t5b_busy", 128'(busy), 128'(0));
        tick(1);
        resetn = 1'b1;
        tick(1);

        // Back-to-back frames 5 and 7.
        b0 = bursts;
        push(32'hFA000005);
        for (int w = 0; w < NR; w++) push(32'h50505050 + 32'(w));
        c0 = lastAcc;
        push(32'hFA000007);
        check("t6_gap", 128'(lastAcc - c0), 128'(SC + 1));
        for (int w = 0; w < NR; w++) push(32'h70707070 + 32'(w));
        waitIdle();
        tick(1);
        check("t6_bursts", 128'(bursts), 128'(b0 + 2));
        check("t6_strobe", 128'(lastStrb), 128'(20'h00080));
        check("t6_data", lastData,
              128'h70707073_70707072_70707071_70707070);

        // Random frames with gaps, bad headers and occasional resets.
        for (int f = 0; f < 250; f++) begin
            kind = int'($urandom_range(0, 9));
            h    = $urandom;
            if (kind == 0) begin
                if (h[31:24] == 8'hFA) h[31:24] = 8'h00;
            end else if (kind == 1) begin
                h[31:24] = 8'hFA;
                h[4:0]   = 5'($urandom_range(20, 31));
            end else begin
                h[31:24] = 8'hFA;
                h[4:0]   = 5'($urandom_range(0, 19));
            end
            if ($urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                tick(int'($urandom_range(1, 3)));
            end
            push(h);
            if (kind >= 2) begin
                for (int w = 0; w < NR; w++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        s_valid = 1'b0;
                        s_data  = $urandom;
                        tick(int'($urandom_range(1, 2)));
                    end
                    if (w == 2 && $urandom_range(0, 24) == 0) begin
                        s_valid = 1'b0;
                        resetn  = 1'b0;
                        tick(1);
                        resetn  = 1'b1;
                        break;
                    end
                    push($urandom);
                end
            end
        end
        waitIdle();
        tick(2);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
